// File: rtl/regwb_pkg.sv
// Shared types and constants for the register write-back front end.
// Holds the register-file geometry (DATA_W, ADDR_W, NUM_REGS), the queued
// write-request record and the arbitration priority encoding.
package regwb_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_queue.sv
// In-order circular buffer of write-back entries.
// Accepts 0, 1 or 2 pushes and at most one pop per cycle.
// Ports:
//   clk, rst              clock, async active-high reset
//   push0_i/push0_entry_i first push slot (written at the write pointer)
//   push1_i/push1_entry_i second push slot (only meaningful with push0_i)
//   pop_i                 remove the head entry (ignored when empty)
//   head_o                head entry, straight from storage flops
//   count_o/full_o/empty_o occupancy
//   age_entry_o/age_valid_o entries ordered oldest (index 0) to youngest
module wb_queue
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push0_i,
  input  wb_entry_t                    push0_entry_i,
  input  logic                         push1_i,
  input  wb_entry_t                    push1_entry_i,
  input  logic                         pop_i,
  output wb_entry_t                    head_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output wb_entry_t [DEPTH-1:0]        age_entry_o,
  output logic [DEPTH-1:0]             age_valid_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  pop_eff;
  logic [CNT_W-1:0]      n_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign pop_eff = pop_i && !empty_o;
  assign n_push  = CNT_W'(push0_i) + CNT_W'(push0_i && push1_i);

  // Pointers are DEPTH-wide (power of two) so plain addition wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push0_i) mem_q[wr_ptr_q] <= push0_entry_i;
      if (push0_i && push1_i) mem_q[wr_ptr_q + PTR_W'(1)] <= push1_entry_i;
      wr_ptr_q <= wr_ptr_q + PTR_W'(n_push);
      if (pop_eff) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q  <= count_q + n_push - CNT_W'(pop_eff);
    end
  end

  always_comb begin
    age_entry_o = '0;
    age_valid_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      age_entry_o[k] = mem_q[rd_ptr_q + PTR_W'(k)];
      age_valid_o[k] = (CNT_W'(k) < count_q);
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Write-side front end of the register file. Arbitrates ALU and load-unit
// write requests into an in-order queue, drains one entry per cycle onto the
// register-file write port and publishes a per-register pending scoreboard.
// Ports:
//   clk, rst                          clock, async active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data  ALU request (valid/ready)
//   ld_valid/ld_ready/ld_rd/ld_data      load-unit request (valid/ready)
//   rf_reg_write/rf_rd/rf_write_data     register-file write port
//   pending                            bit r set while a queued entry targets r
//   q_full, q_empty                    queue occupancy flags
//   byp_rs1/byp_rs2, byp*_hit/byp*_data  read-forwarding lookups
// Build option: WB_BYPASS_EN enables forwarding; when undefined the bypass
// outputs are tied to zero and the byp_rs inputs are ignored.
//
// Handshake: a request transfers on a rising edge where valid and ready are
// both high. Ready depends combinationally on the registered queue count, the
// priority flop and both valids; a source may change or drop its request
// freely until it transfers.
module reg_writeback_unit
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_W-1:0]   ld_rd,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                rf_reg_write,
  output logic [ADDR_W-1:0]   rf_rd,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic [NUM_REGS-1:0] pending,
  output logic                q_full,
  output logic                q_empty,
  input  logic [ADDR_W-1:0]   byp_rs1,
  input  logic [ADDR_W-1:0]   byp_rs2,
  output logic                byp1_hit,
  output logic [DATA_W-1:0]   byp1_data,
  output logic                byp2_hit,
  output logic [DATA_W-1:0]   byp2_data
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_src_e               prio_q, prio_d;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      space;
  logic                  alu_push, ld_push;
  logic                  push0, push1;
  wb_entry_t             alu_entry, ld_entry, entry0, entry1, head;
  wb_entry_t [DEPTH-1:0] age_entry;
  logic [DEPTH-1:0]      age_valid;

  assign alu_entry = '{rd: alu_rd, data: alu_data};
  assign ld_entry  = '{rd: ld_rd,  data: ld_data};

  // Space comes from the registered count only; a same-cycle pop does not
  // free a slot for this cycle's pushes.
  assign space = CNT_W'(DEPTH) - count;

  // With a single free slot exactly one ready is raised: the lone requester,
  // the priority holder under contention, or the priority holder when idle.
  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (space >= CNT_W'(2)) begin
      alu_ready = 1'b1;
      ld_ready  = 1'b1;
    end else if (space == CNT_W'(1)) begin
      if (alu_valid && ld_valid) begin
        alu_ready = (prio_q == SRC_ALU);
        ld_ready  = (prio_q == SRC_LD);
      end else if (alu_valid) begin
        alu_ready = 1'b1;
      end else if (ld_valid) begin
        ld_ready  = 1'b1;
      end else begin
        alu_ready = (prio_q == SRC_ALU);
        ld_ready  = (prio_q == SRC_LD);
      end
    end
  end

  assign alu_push = alu_valid && alu_ready;
  assign ld_push  = ld_valid && ld_ready;
  assign push0    = alu_push || ld_push;
  assign push1    = alu_push && ld_push;

  // The priority holder takes slot 0 on a double push so it drains first.
  always_comb begin
    entry0 = alu_push ? alu_entry : ld_entry;
    entry1 = ld_entry;
    if (push1 && (prio_q == SRC_LD)) begin
      entry0 = ld_entry;
      entry1 = alu_entry;
    end
  end

  // Priority flips on every contended cycle, granted or not.
  always_comb begin
    prio_d = prio_q;
    if (alu_valid && ld_valid) prio_d = (prio_q == SRC_ALU) ? SRC_LD : SRC_ALU;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= SRC_ALU;
    else     prio_q <= prio_d;
  end

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk           (clk),
    .rst           (rst),
    .push0_i       (push0),
    .push0_entry_i (entry0),
    .push1_i       (push1),
    .push1_entry_i (entry1),
    .pop_i         (!q_empty),
    .head_o        (head),
    .count_o       (count),
    .full_o        (q_full),
    .empty_o       (q_empty),
    .age_entry_o   (age_entry),
    .age_valid_o   (age_valid)
  );

  // The register file never stalls, so the head drains every non-empty cycle.
  assign rf_reg_write  = !q_empty;
  assign rf_rd         = head.rd;
  assign rf_write_data = head.data;

  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_valid[k]) pending[age_entry[k].rd] = 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    byp1_hit  = 1'b0;
    byp1_data = '0;
    byp2_hit  = 1'b0;
    byp2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_valid[k] && (age_entry[k].rd == byp_rs1)) begin
        byp1_hit  = 1'b1;
        byp1_data = age_entry[k].data;
      end
      if (age_valid[k] && (age_entry[k].rd == byp_rs2)) begin
        byp2_hit  = 1'b1;
        byp2_data = age_entry[k].data;
      end
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_rs1, byp_rs2};
  assign byp1_hit   = 1'b0;
  assign byp1_data  = '0;
  assign byp2_hit   = 1'b0;
  assign byp2_data  = '0;
`endif

endmodule
